// File: rtl/bp_be_pkg.sv
// Shared types for the D$ response scoreboard: verdict FSM states,
// failure causes and the mismatch counter width.
package bp_be_pkg;

   localparam int bp_be_dcache_sb_count_width_gp = 16;

   typedef enum logic [1:0] {
      e_sb_run   = 2'd0
     ,e_sb_drain = 2'd1
     ,e_sb_pass  = 2'd2
     ,e_sb_fail  = 2'd3
   } bp_be_dcache_sb_state_e;

   typedef enum logic [1:0] {
      e_sb_cause_none       = 2'd0
     ,e_sb_cause_mismatch   = 2'd1
     ,e_sb_cause_unexpected = 2'd2
     ,e_sb_cause_timeout    = 2'd3
   } bp_be_dcache_sb_cause_e;

   // Checking is live only until a verdict has been reached.
   function automatic logic bp_be_dcache_sb_active(input bp_be_dcache_sb_state_e s);
      return (s == e_sb_run) || (s == e_sb_drain);
   endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO: one write port (valid/ready), one read port
// (valid/yumi), and an occupancy count. Ready depends on registered state only.
module bsg_fifo_1r1w_small
   #(parameter int width_p = 64
    ,parameter int els_p   = 8
    )
   (input  logic                       clk_i
   ,input  logic                       reset_i
   ,input  logic                       v_i
   ,input  logic [width_p-1:0]         data_i
   ,output logic                       ready_o
   ,output logic                       v_o
   ,output logic [width_p-1:0]         data_o
   ,input  logic                       yumi_i
   ,output logic [$clog2(els_p+1)-1:0] count_o
   );

   localparam int ptr_width_lp   = $clog2(els_p);
   localparam int count_width_lp = $clog2(els_p+1);

   logic [width_p-1:0]        mem_r [els_p];
   logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
   logic [count_width_lp-1:0] count_r;
   logic                      enq, deq;

   assign ready_o = (count_r != count_width_lp'(els_p));
   assign v_o     = (count_r != '0);
   assign data_o  = mem_r[rptr_r];
   assign count_o = count_r;
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   // Pointers and occupancy; els_p is a power of 2 so pointers wrap naturally.
   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
         if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
         if (enq & ~deq)
            count_r <= count_r + count_width_lp'(1);
         else if (deq & ~enq)
            count_r <= count_r - count_width_lp'(1);
      end
   end

   // Entry storage, written on accepted pushes.
   // NOTE: storage is not reset; entries are only read once the count says they are valid.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_be_dcache_resp_scoreboard.sv
// D$ response scoreboard: queues expected load data, compares each response
// against the queue head, counts mismatches and produces a sticky verdict.
// Optional byte-mask compare is enabled by defining BP_DCACHE_SB_MASK_EN.
module bp_be_dcache_resp_scoreboard
   import bp_be_pkg::*;
   #(parameter int dword_width_p    = 64
    ,parameter int els_p            = 8
    ,parameter int timeout_cycles_p = 1024
    )
   (input  logic                                      clk_i
   ,input  logic                                      reset_i
   ,input  logic                                      exp_v_i
   ,input  logic [dword_width_p-1:0]                  exp_data_i
   ,input  logic [dword_width_p/8-1:0]                exp_mask_i
   ,output logic                                      exp_ready_o
   ,input  logic                                      resp_v_i
   ,input  logic [dword_width_p-1:0]                  resp_data_i
   ,input  logic                                      done_i
   ,output logic [$clog2(els_p+1)-1:0]                outstanding_o
   ,output logic [bp_be_dcache_sb_count_width_gp-1:0] mismatch_count_o
   ,output logic                                      pass_o
   ,output logic                                      fail_o
   ,output logic [1:0]                                fail_cause_o
   );

   localparam int mask_width_lp  = dword_width_p/8;
   localparam int count_width_lp = $clog2(els_p+1);
   localparam int timer_width_lp = $clog2(timeout_cycles_p);
`ifdef BP_DCACHE_SB_MASK_EN
   localparam int entry_width_lp = dword_width_p + mask_width_lp;
`else
   localparam int entry_width_lp = dword_width_p;
`endif

   bp_be_dcache_sb_state_e                     state_r, state_n;
   bp_be_dcache_sb_cause_e                     cause_r, cause_n;
   logic [count_width_lp-1:0]                  occ_r, occ_n;
   logic [timer_width_lp-1:0]                  timer_r;
   logic [bp_be_dcache_sb_count_width_gp-1:0]  mismatch_count_r;
   logic [entry_width_lp-1:0]                  fifo_data_li, fifo_data_lo;
   logic [dword_width_p-1:0]                   head_data, cmp_mask;
   logic fifo_v_lo, fifo_ready_lo;
   logic active, push_accept, pop, data_mismatch, mismatch_now, unexpected_resp, timeout_hit;

   // Once a verdict is reached, pushes and responses no longer touch the queue.
   assign active      = bp_be_dcache_sb_active(state_r);
   assign push_accept = exp_v_i & active & fifo_ready_lo;
   assign pop         = resp_v_i & active & fifo_v_lo;
   assign head_data   = fifo_data_lo[dword_width_p-1:0];

`ifdef BP_DCACHE_SB_MASK_EN
   logic [mask_width_lp-1:0] head_mask;
   assign fifo_data_li = {exp_mask_i, exp_data_i};
   assign head_mask    = fifo_data_lo[entry_width_lp-1 -: mask_width_lp];
`else
   logic unused_mask;
   assign fifo_data_li = exp_data_i;
   assign unused_mask  = ^exp_mask_i;
`endif

   bsg_fifo_1r1w_small
     #(.width_p(entry_width_lp), .els_p(els_p))
     exp_fifo
      (.clk_i   (clk_i)
      ,.reset_i (reset_i)
      ,.v_i     (exp_v_i & active)
      ,.data_i  (fifo_data_li)
      ,.ready_o (fifo_ready_lo)
      ,.v_o     (fifo_v_lo)
      ,.data_o  (fifo_data_lo)
      ,.yumi_i  (pop)
      ,.count_o (occ_r)
      );

   // Byte-granular compare of the queue head against the response.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cmp_mask = '1;
`ifdef BP_DCACHE_SB_MASK_EN
      for (int i = 0; i < mask_width_lp; i++)
         cmp_mask[8*i +: 8] = {8{head_mask[i]}};
`endif
      data_mismatch = |((head_data ^ resp_data_i) & cmp_mask);
   end

   assign mismatch_now    = pop & data_mismatch;
   assign unexpected_resp = resp_v_i & ((active & ~fifo_v_lo) | (state_r == e_sb_pass));
   assign timeout_hit     = active & (timer_r == timer_width_lp'(timeout_cycles_p-1));
   assign occ_n           = occ_r + count_width_lp'(push_accept) - count_width_lp'(pop);

   // Next-state and cause selection; fail events override, mismatch cause latches once.
   always_comb begin
      state_n = state_r;
      cause_n = cause_r;
      unique case (state_r)
         e_sb_run, e_sb_drain: begin
            if (unexpected_resp) begin
               state_n = e_sb_fail;
               cause_n = e_sb_cause_unexpected;
            end else if (timeout_hit) begin
               state_n = e_sb_fail;
               cause_n = e_sb_cause_timeout;
            end else begin
               if (mismatch_now && (cause_r == e_sb_cause_none))
                  cause_n = e_sb_cause_mismatch;
               if (state_r == e_sb_run) begin
                  if (done_i) state_n = e_sb_drain;
               end else if (occ_n == '0) begin
                  state_n = ((mismatch_count_r != '0) || mismatch_now) ? e_sb_fail : e_sb_pass;
               end
            end
         end
         e_sb_pass: begin
            if (resp_v_i) begin
               state_n = e_sb_fail;
               cause_n = e_sb_cause_unexpected;
            end
         end
         default: ;
      endcase
   end

   // State, cause, saturating mismatch count and response-gap timer.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r          <= e_sb_run;
         cause_r          <= e_sb_cause_none;
         mismatch_count_r <= '0;
         timer_r          <= '0;
      end else begin
         state_r <= state_n;
         cause_r <= cause_n;
         if (mismatch_now && (mismatch_count_r != '1))
            mismatch_count_r <= mismatch_count_r + 1'b1;
         if (~active || resp_v_i || (occ_r == '0))
            timer_r <= '0;
         else
            timer_r <= timer_r + timer_width_lp'(1);
      end
   end

   assign exp_ready_o      = fifo_ready_lo;
   assign outstanding_o    = occ_r;
   assign mismatch_count_o = mismatch_count_r;
   assign pass_o           = (state_r == e_sb_pass);
   assign fail_o           = (state_r == e_sb_fail);
   assign fail_cause_o     = cause_r;

endmodule

// File: tb/tb_bp_be_dcache_resp_scoreboard.sv
// Self-checking bench for bp_be_dcache_resp_scoreboard (64-bit data, 8 entries,
// 16-cycle timeout). Directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_bp_be_dcache_resp_scoreboard;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  m;
   } entry_t;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        exp_v_i = 1'b0;
   logic [63:0] exp_data_i = '0;
   logic [7:0]  exp_mask_i = '0;
   logic        exp_ready_o;
   logic        resp_v_i = 1'b0;
   logic [63:0] resp_data_i = '0;
   logic        done_i = 1'b0;
   logic [3:0]  outstanding_o;
   logic [15:0] mismatch_count_o;
   logic        pass_o, fail_o;
   logic [1:0]  fail_cause_o;

   int checks = 0;
   int failures = 0;

   bp_be_dcache_resp_scoreboard
     #(.dword_width_p(64), .els_p(8), .timeout_cycles_p(16))
     dut
      (.clk_i(clk_i), .reset_i(reset_i)
      ,.exp_v_i(exp_v_i), .exp_data_i(exp_data_i), .exp_mask_i(exp_mask_i)
      ,.exp_ready_o(exp_ready_o)
      ,.resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .done_i(done_i)
      ,.outstanding_o(outstanding_o), .mismatch_count_o(mismatch_count_o)
      ,.pass_o(pass_o), .fail_o(fail_o), .fail_cause_o(fail_cause_o)
      );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      exp_v_i = 0; resp_v_i = 0; done_i = 0;
      exp_data_i = '0; exp_mask_i = '0; resp_data_i = '0;
      reset_i = 1;
      @(posedge clk_i);
      #1 reset_i = 0;
   endtask

   // Byte-wise expectation rule: with masking, only enabled bytes count.
   function automatic bit model_match(input logic [63:0] e, input logic [7:0] m, input logic [63:0] r);
      for (int b = 0; b < 8; b++) begin
`ifdef BP_DCACHE_SB_MASK_EN
         if (m[b] && (e[8*b +: 8] !== r[8*b +: 8])) return 1'b0;
`else
         if (e[8*b +: 8] !== r[8*b +: 8]) return 1'b0;
`endif
      end
      return 1'b1;
   endfunction

   task automatic test_reset();
      do_reset();
      repeat (3) step();
      if (exp_ready_o !== 1'b1) begin failures++; $display("FAIL reset.ready got=%b exp=1", exp_ready_o); end checks++;
      if (outstanding_o !== 4'd0) begin failures++; $display("FAIL reset.outstanding got=%0d exp=0", outstanding_o); end checks++;
      if (mismatch_count_o !== 16'd0) begin failures++; $display("FAIL reset.mismatch got=%0d exp=0", mismatch_count_o); end checks++;
      if ({pass_o, fail_o, fail_cause_o} !== 4'b0000) begin failures++; $display("FAIL reset.verdict got=%b%b cause=%0d exp=00 cause=0", pass_o, fail_o, fail_cause_o); end checks++;
   endtask

   task automatic test_pass_seq();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp_v_i = 1; exp_data_i = 64'h11 * (i + 1); exp_mask_i = 8'hFF; step();
      end
      exp_v_i = 0;
      if (outstanding_o !== 4'd3) begin failures++; $display("FAIL pass_seq.outstanding_after_push got=%0d exp=3", outstanding_o); end checks++;
      for (int i = 0; i < 3; i++) begin
         resp_v_i = 1; resp_data_i = 64'h11 * (i + 1); step();
      end
      resp_v_i = 0;
      if (outstanding_o !== 4'd0) begin failures++; $display("FAIL pass_seq.outstanding_after_resp got=%0d exp=0", outstanding_o); end checks++;
      done_i = 1; step();
      if (pass_o !== 1'b0) begin failures++; $display("FAIL pass_seq.pass_early got=%b exp=0", pass_o); end checks++;
      step();
      if (pass_o !== 1'b1 || fail_o !== 1'b0) begin failures++; $display("FAIL pass_seq.verdict got=pass%b fail%b exp=pass1 fail0", pass_o, fail_o); end checks++;
      if (mismatch_count_o !== 16'd0 || fail_cause_o !== 2'd0) begin failures++; $display("FAIL pass_seq.counts got=mm%0d cause%0d exp=mm0 cause0", mismatch_count_o, fail_cause_o); end checks++;
      // A response after pass is unexpected.
      done_i = 0; resp_v_i = 1; step(); resp_v_i = 0;
      if (fail_o !== 1'b1 || pass_o !== 1'b0 || fail_cause_o !== 2'd2) begin failures++; $display("FAIL pass_seq.resp_after_pass got=fail%b pass%b cause%0d exp=fail1 pass0 cause2", fail_o, pass_o, fail_cause_o); end checks++;
   endtask

   task automatic test_mismatch();
      do_reset();
      exp_v_i = 1; exp_data_i = 64'hDEAD; exp_mask_i = 8'hFF; step(); exp_v_i = 0;
      resp_v_i = 1; resp_data_i = 64'hBEEF; step(); resp_v_i = 0;
      if (mismatch_count_o !== 16'd1) begin failures++; $display("FAIL mismatch.count got=%0d exp=1", mismatch_count_o); end checks++;
      if (fail_cause_o !== 2'd1 || fail_o !== 1'b0) begin failures++; $display("FAIL mismatch.cause_pre got=cause%0d fail%b exp=cause1 fail0", fail_cause_o, fail_o); end checks++;
      done_i = 1; step(); step(); done_i = 0;
      if (fail_o !== 1'b1 || pass_o !== 1'b0 || fail_cause_o !== 2'd1) begin failures++; $display("FAIL mismatch.verdict got=fail%b pass%b cause%0d exp=fail1 pass0 cause1", fail_o, pass_o, fail_cause_o); end checks++;
   endtask

   task automatic test_unexpected();
      do_reset();
      resp_v_i = 1; resp_data_i = 64'h1234; step(); resp_v_i = 0;
      if (fail_o !== 1'b1 || fail_cause_o !== 2'd2) begin failures++; $display("FAIL unexpected.verdict got=fail%b cause%0d exp=fail1 cause2", fail_o, fail_cause_o); end checks++;
      // Absorbing: further responses are ignored.
      resp_v_i = 1; step(); resp_v_i = 0;
      if (fail_o !== 1'b1 || fail_cause_o !== 2'd2) begin failures++; $display("FAIL unexpected.sticky got=fail%b cause%0d exp=fail1 cause2", fail_o, fail_cause_o); end checks++;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         exp_v_i = 1; exp_data_i = 64'h1000 + 64'(i); exp_mask_i = 8'hFF; step();
      end
      if (exp_ready_o !== 1'b0 || outstanding_o !== 4'd8) begin failures++; $display("FAIL full.state got=ready%b occ%0d exp=ready0 occ8", exp_ready_o, outstanding_o); end checks++;
      exp_data_i = 64'h9999; step();
      if (outstanding_o !== 4'd8) begin failures++; $display("FAIL full.ninth_push got=%0d exp=8", outstanding_o); end checks++;
      // Response while full: the held push is still refused.
      resp_v_i = 1; resp_data_i = 64'h1000; step();
      if (outstanding_o !== 4'd7 || exp_ready_o !== 1'b1) begin failures++; $display("FAIL full.after_pop got=occ%0d ready%b exp=occ7 ready1", outstanding_o, exp_ready_o); end checks++;
      resp_data_i = 64'h1001; exp_data_i = 64'h1008; step();
      exp_v_i = 0; resp_v_i = 0;
      if (outstanding_o !== 4'd7 || mismatch_count_o !== 16'd0) begin failures++; $display("FAIL full.push_pop got=occ%0d mm%0d exp=occ7 mm0", outstanding_o, mismatch_count_o); end checks++;
   endtask

   task automatic test_timeout();
      do_reset();
      exp_v_i = 1; exp_data_i = 64'h55; exp_mask_i = 8'hFF; step(); exp_v_i = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (fail_o !== (k >= 16)) begin failures++; $display("FAIL timeout.fail_at_cycle%0d got=%b exp=%b", k, fail_o, (k >= 16)); end checks++;
      end
      if (fail_cause_o !== 2'd3) begin failures++; $display("FAIL timeout.cause got=%0d exp=3", fail_cause_o); end checks++;
      // Asynchronous reset in the middle of a count.
      do_reset();
      exp_v_i = 1; step(); exp_v_i = 0;
      repeat (5) step();
      #2 reset_i = 1;
      #1;
      if ({exp_ready_o, outstanding_o, mismatch_count_o, pass_o, fail_o, fail_cause_o} !== {1'b1, 4'd0, 16'd0, 1'b0, 1'b0, 2'd0}) begin
         failures++; $display("FAIL timeout.async_reset got=ready%b occ%0d mm%0d pass%b fail%b cause%0d exp=ready1 occ0 mm0 pass0 fail0 cause0", exp_ready_o, outstanding_o, mismatch_count_o, pass_o, fail_o, fail_cause_o);
      end
      checks++;
      @(posedge clk_i); #1 reset_i = 0;
   endtask

   task automatic test_mask();
      bit exp_match;
      exp_match = model_match(64'h00FF, 8'h01, 64'hABFF);
      do_reset();
      exp_v_i = 1; exp_data_i = 64'h00FF; exp_mask_i = 8'h01; step(); exp_v_i = 0;
      resp_v_i = 1; resp_data_i = 64'hABFF; step(); resp_v_i = 0;
      done_i = 1; step(); step(); done_i = 0;
      if (mismatch_count_o !== (exp_match ? 16'd0 : 16'd1)) begin failures++; $display("FAIL mask.count got=%0d exp=%0d", mismatch_count_o, exp_match ? 0 : 1); end checks++;
      if (pass_o !== exp_match || fail_o !== !exp_match) begin failures++; $display("FAIL mask.verdict got=pass%b fail%b exp=pass%b", pass_o, fail_o, exp_match); end checks++;
   endtask

   task automatic test_random(input bit corrupt, input int n_cycles);
      entry_t q[$];
      int mm = 0;
      int gap = 0;
      do_reset();
      for (int c = 0; c < n_cycles; c++) begin
         bit do_push, do_resp;
         entry_t e;
         logic [63:0] rd;
         int sz;
         sz = q.size();
         do_push = ($urandom_range(0, 2) != 0);
         do_resp = (sz > 0) && (($urandom_range(0, 1) == 1) || (gap >= 6));
         e.d = {$urandom, $urandom};
         e.m = 8'($urandom);
         rd  = {$urandom, $urandom};
         if (do_resp) begin
            rd = q[0].d;
            if (corrupt && ($urandom_range(0, 3) == 0)) rd = rd ^ ({$urandom, $urandom} | 64'h1);
         end
         exp_v_i = do_push; exp_data_i = e.d; exp_mask_i = e.m;
         resp_v_i = do_resp; resp_data_i = rd;
         if (exp_ready_o !== (sz < 8)) begin failures++; $display("FAIL random.ready cyc=%0d got=%b exp=%b", c, exp_ready_o, (sz < 8)); end checks++;
         if (do_resp) begin
            if (!model_match(q[0].d, q[0].m, rd)) mm++;
            void'(q.pop_front());
            gap = 0;
         end else begin
            gap = (sz > 0) ? gap + 1 : 0;
         end
         if (do_push && sz < 8) q.push_back(e);
         step();
         if (outstanding_o !== 4'(q.size()) || mismatch_count_o !== 16'(mm)) begin
            failures++; $display("FAIL random.state cyc=%0d got=occ%0d mm%0d exp=occ%0d mm%0d", c, outstanding_o, mismatch_count_o, q.size(), mm);
         end
         checks++;
      end
      exp_v_i = 0; done_i = 1;
      while (q.size() > 0) begin
         resp_v_i = 1; resp_data_i = q[0].d; void'(q.pop_front()); step();
      end
      resp_v_i = 0;
      step(); step();
      done_i = 0;
      if (pass_o !== (mm == 0) || fail_o !== (mm != 0)) begin failures++; $display("FAIL random.verdict got=pass%b fail%b exp=pass%b (mm=%0d)", pass_o, fail_o, (mm == 0), mm); end checks++;
      if (fail_cause_o !== ((mm != 0) ? 2'd1 : 2'd0) || mismatch_count_o !== 16'(mm)) begin failures++; $display("FAIL random.final got=cause%0d mm%0d exp=cause%0d mm%0d", fail_cause_o, mismatch_count_o, (mm != 0), mm); end checks++;
   endtask

   initial begin
      test_reset();
      test_pass_seq();
      test_mismatch();
      test_unexpected();
      test_full();
      test_timeout();
      test_mask();
      test_random(1'b0, 200);
      test_random(1'b1, 200);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
